// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared constants for the fetch sequencer slice: default widths,
//   the fetch FSM state encodings and a small helper describing which
//   states keep a memory request on the bus.
package fetch_sequencer_pkg;

  localparam int          WORD_SIZE_DEF  = 32;
  localparam logic [31:0] PC_INITIAL_DEF = 32'h0000_0000;
  localparam int          MAX_WAIT_DEF   = 15;

  typedef logic [1:0] fs_state_t;

  // FETCH: request outstanding; HOLD: response parked in the hold buffer;
  // DROP: request outstanding but its response is stale after a redirect.
  localparam logic [1:0] FS_FETCH = 2'd0;
  localparam logic [1:0] FS_HOLD  = 2'd1;
  localparam logic [1:0] FS_DROP  = 2'd2;

  // Only HOLD idles the memory port; every other state has a request out.
  function automatic logic stateRequests(input fs_state_t s);
    return (s != FS_HOLD);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles every non-clock/reset signal of the fetch sequencer:
//     execute side : pc_src_e, pc_target_e
//     hazard side  : stall_d (in), stall_f (out)
//     memory side  : imem_req, imem_addr (out), imem_ack, imem_rdata (in)
//     decode side  : pc_f, instr_d, pc_d, pc_plus1_d, valid_d, fetch_err (out)
//   master = the fetch sequencer's view, slave = the surrounding pipeline
//   and instruction memory.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
);

  logic                 pc_src_e;
  logic [WORD_SIZE-1:0] pc_target_e;
  logic                 stall_d;
  logic                 imem_req;
  logic [WORD_SIZE-1:0] imem_addr;
  logic                 imem_ack;
  logic [WORD_SIZE-1:0] imem_rdata;
  logic [WORD_SIZE-1:0] pc_f;
  logic                 stall_f;
  logic [WORD_SIZE-1:0] instr_d;
  logic [WORD_SIZE-1:0] pc_d;
  logic [WORD_SIZE-1:0] pc_plus1_d;
  logic                 valid_d;
  logic                 fetch_err;

  modport master (
    input  pc_src_e, pc_target_e, stall_d, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc_f, stall_f,
           instr_d, pc_d, pc_plus1_d, valid_d, fetch_err
  );

  modport slave (
    output pc_src_e, pc_target_e, stall_d, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc_f, stall_f,
           instr_d, pc_d, pc_plus1_d, valid_d, fetch_err
  );

endinterface

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer
//   One-entry {instr, pc} parking register used when a fetch response
//   arrives while decode is stalled.
//   Ports: clk, rst_n (async active-low)
//          load_i  - capture instr_i/pc_i and mark full
//          clear_i - mark empty (data left as-is, it is ignored when empty)
//          full_o, instr_o, pc_o - current contents
module fetch_hold_buffer
  import fetch_sequencer_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic             full_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             full_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;

  // Load wins over clear so a simultaneous request never loses a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (clear_i) begin
      full_q  <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Drives instruction fetch over a req/ack memory port, owns the fetch PC
//   and the F->D pipeline register, parks one response when decode stalls,
//   and handles execute-stage redirects (including ones that land while a
//   request is still outstanding).
//   Ports: clk, rst_n (async active-low), bus (fetch_sequencer_if.master).
//   Parameters: WORD_SIZE, PC_INITIAL, MAX_WAIT (ack timeout in cycles).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                   WORD_SIZE  = WORD_SIZE_DEF,
  parameter logic [WORD_SIZE-1:0] PC_INITIAL = '0,
  parameter int                   MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  fs_state_t            state_q,        state_d;
  logic [WORD_SIZE-1:0] fetchPc_q,      fetchPc_d;
  logic [WORD_SIZE-1:0] pendTarget_q,   pendTarget_d;
  logic [WORD_SIZE-1:0] decInstr_q,     decInstr_d;
  logic [WORD_SIZE-1:0] decPc_q,        decPc_d;
  logic [WORD_SIZE-1:0] decPcPlus1_q,   decPcPlus1_d;
  logic                 decValid_q,     decValid_d;
  logic [WAIT_W-1:0]    waitCnt_q,      waitCnt_d;
  logic                 fetchErr_q,     fetchErr_d;

  logic                 reqActive;
  logic                 ackTaken;
  logic [WORD_SIZE-1:0] fetchPcPlus1;
  logic                 bufLoad;
  logic                 bufClear;
  logic                 bufFull;
  logic [WORD_SIZE-1:0] bufInstr;
  logic [WORD_SIZE-1:0] bufPc;

  // The request is forced low while reset is held, so an ack can only be
  // taken once reset has been released.
  assign reqActive    = rst_n & stateRequests(state_q);
  assign ackTaken     = bus.imem_ack & reqActive;
  assign fetchPcPlus1 = fetchPc_q + WORD_SIZE'(1);

  fetch_hold_buffer #(
    .WIDTH (WORD_SIZE)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (bufLoad),
    .clear_i (bufClear),
    .instr_i (bus.imem_rdata),
    .pc_i    (fetchPc_q),
    .full_o  (bufFull),
    .instr_o (bufInstr),
    .pc_o    (bufPc)
  );

  // Next-state logic: FSM, fetch PC, pending redirect target and D register.
  // Redirects always take priority; a redirect without an ack cannot move
  // the address (it must stay stable until acked), so it parks the target
  // and goes to DROP to discard the stale response.
  always_comb begin
    state_d      = state_q;
    fetchPc_d    = fetchPc_q;
    pendTarget_d = pendTarget_q;
    decInstr_d   = decInstr_q;
    decPc_d      = decPc_q;
    decPcPlus1_d = decPcPlus1_q;
    decValid_d   = decValid_q;
    bufLoad      = 1'b0;
    bufClear     = 1'b0;

    case (state_q)
      FS_FETCH: begin
        if (bus.pc_src_e) begin
          decValid_d = 1'b0;
          if (ackTaken) begin
            fetchPc_d = bus.pc_target_e;
          end else begin
            pendTarget_d = bus.pc_target_e;
            state_d      = FS_DROP;
          end
        end else if (ackTaken) begin
          fetchPc_d = fetchPcPlus1;
          if (!bus.stall_d) begin
            decInstr_d   = bus.imem_rdata;
            decPc_d      = fetchPc_q;
            decPcPlus1_d = fetchPcPlus1;
            decValid_d   = 1'b1;
          end else begin
            bufLoad = 1'b1;
            state_d = FS_HOLD;
          end
        end else if (!bus.stall_d) begin
          decValid_d = 1'b0;
        end
      end

      FS_HOLD: begin
        if (bus.pc_src_e) begin
          bufClear   = 1'b1;
          fetchPc_d  = bus.pc_target_e;
          decValid_d = 1'b0;
          state_d    = FS_FETCH;
        end else if (!bus.stall_d) begin
          bufClear     = 1'b1;
          decInstr_d   = bufInstr;
          decPc_d      = bufPc;
          decPcPlus1_d = bufPc + WORD_SIZE'(1);
          decValid_d   = bufFull;
          state_d      = FS_FETCH;
        end
      end

      FS_DROP: begin
        // A redirect in the same cycle as the ack is newer than the one
        // already parked, so it wins.
        if (ackTaken) begin
          fetchPc_d = bus.pc_src_e ? bus.pc_target_e : pendTarget_q;
          state_d   = FS_FETCH;
        end else if (bus.pc_src_e) begin
          pendTarget_d = bus.pc_target_e;
        end
      end

      default: begin
        state_d = FS_FETCH;
      end
    endcase
  end

  // Ack-timeout watchdog: counts unanswered request cycles, saturating, and
  // latches fetch_err once the limit is reached. The request itself keeps
  // going; the flag only reports the timeout.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (ackTaken || (state_d == FS_HOLD && state_q != FS_HOLD)) begin
      waitCnt_d = '0;
    end else if (reqActive && waitCnt_q != WAIT_MAX) begin
      waitCnt_d = waitCnt_q + WAIT_W'(1);
    end
    fetchErr_d = fetchErr_q | (waitCnt_d == WAIT_MAX);
  end

  // State registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FS_FETCH;
      fetchPc_q    <= PC_INITIAL;
      pendTarget_q <= '0;
      decInstr_q   <= '0;
      decPc_q      <= '0;
      decPcPlus1_q <= '0;
      decValid_q   <= 1'b0;
      waitCnt_q    <= '0;
      fetchErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetchPc_q    <= fetchPc_d;
      pendTarget_q <= pendTarget_d;
      decInstr_q   <= decInstr_d;
      decPc_q      <= decPc_d;
      decPcPlus1_q <= decPcPlus1_d;
      decValid_q   <= decValid_d;
      waitCnt_q    <= waitCnt_d;
      fetchErr_q   <= fetchErr_d;
    end
  end

  // Fetch PC is frozen whenever we are not in FETCH, while a request waits
  // for its ack, or when an ack has to be parked because decode is stalled.
  assign bus.stall_f = (state_q != FS_FETCH)
                     | (bus.imem_req & ~bus.imem_ack)
                     | ((state_q == FS_FETCH) & bus.imem_ack & bus.stall_d);

  assign bus.imem_req   = reqActive;
  assign bus.imem_addr  = fetchPc_q;
  assign bus.pc_f       = fetchPc_q;
  assign bus.instr_d    = decInstr_q;
  assign bus.pc_d       = decPc_q;
  assign bus.pc_plus1_d = decPcPlus1_q;
  assign bus.valid_d    = decValid_q;
  assign bus.fetch_err  = fetchErr_q;

endmodule
